// File: rtl/imem_fetch_ctrl_if.sv
// Fetch-side bus bundle: IMEM read port plus decode valid/ready handshake.
// master = fetch controller, slave = IMEM/decode environment.
interface imem_fetch_ctrl_if;
   // IMEM read port
   logic        imem_rd_en;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   // decode handshake
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_ready;

   modport master (
      output imem_rd_en,
      output imem_addr,
      input  imem_rdata,
      output instr_valid,
      output instr,
      output instr_pc,
      input  instr_ready
   );

   modport slave (
      input  imem_rd_en,
      input  imem_addr,
      output imem_rdata,
      input  instr_valid,
      input  instr,
      input  instr_pc,
      output instr_ready
   );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer: owns PC, issues one IMEM read per cycle, buffers
// returned words with their PC in a DEPTH-entry FIFO, handles redirect/halt.
// Ports: clk, reset (sync, active-high), bus (imem_fetch_ctrl_if.master),
// halt, branch_taken, branch_target, misalign_err, fetch_count.
module imem_fetch_ctrl #(
   parameter int unsigned DEPTH    = 2,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic                     clk,
   input  logic                     reset,
   imem_fetch_ctrl_if.master        bus,
   input  logic                     halt,
   input  logic                     branch_taken,
   input  logic [31:0]              branch_target,
   output logic                     misalign_err,
   output logic [31:0]              fetch_count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

   logic [31:0]   pc_q, pc_d;
   logic [31:0]   req_pc_q, req_pc_d;
   logic          inflight_q, inflight_d;
   logic          squash_q, squash_d;
   logic [AW-1:0] head_q, head_d;
   logic [AW-1:0] tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;
   logic [31:0]   fetch_count_q, fetch_count_d;
   logic          misalign_q, misalign_d;

   logic [31:0]   buf_data_q [DEPTH];
   logic [31:0]   buf_pc_q   [DEPTH];

   logic          pop;
   logic          push;
   logic          issue;
   logic [CW:0]   occupancy;

   // Handshake and issue decisions
   always_comb begin
      bus.instr_valid = !reset && (count_q != '0);
      bus.instr       = buf_data_q[head_q];
      bus.instr_pc    = buf_pc_q[head_q];

      pop  = bus.instr_valid && bus.instr_ready && !branch_taken;
      // a redirect flushes whatever returns this cycle
      push = inflight_q && !squash_q && !branch_taken;

      // slots already owed: buffered + in flight, less what leaves now
      occupancy = (CW+1)'(count_q)
                + (CW+1)'(inflight_q)
                - (CW+1)'(pop);

      issue = !reset && !halt && !branch_taken
              && (occupancy < DEPTH_W);

      bus.imem_rd_en = issue;
      bus.imem_addr  = pc_q;
   end

   // Next-state
   always_comb begin
      pc_d          = pc_q;
      req_pc_d      = req_pc_q;
      inflight_d    = issue;
      squash_d      = 1'b0;
      head_d        = head_q + AW'(pop);
      tail_d        = tail_q + AW'(push);
      count_d       = count_q + CW'(push) - CW'(pop);
      fetch_count_d = fetch_count_q + 32'(pop);
      misalign_d    = 1'b0;

      if (issue) begin
         pc_d     = pc_q + 32'd4;
         req_pc_d = pc_q;
      end

      if (branch_taken) begin
         pc_d       = {branch_target[31:2], 2'b00};
         head_d     = '0;
         tail_d     = '0;
         count_d    = '0;
         // a back-to-back redirect keeps squash set
         squash_d   = inflight_q || squash_q;
         misalign_d = (branch_target[1:0] != 2'b00);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q          <= RESET_PC;
         req_pc_q      <= RESET_PC;
         inflight_q    <= 1'b0;
         squash_q      <= 1'b0;
         head_q        <= '0;
         tail_q        <= '0;
         count_q       <= '0;
         fetch_count_q <= '0;
         misalign_q    <= 1'b0;
      end else begin
         pc_q          <= pc_d;
         req_pc_q      <= req_pc_d;
         inflight_q    <= inflight_d;
         squash_q      <= squash_d;
         head_q        <= head_d;
         tail_q        <= tail_d;
         count_q       <= count_d;
         fetch_count_q <= fetch_count_d;
         misalign_q    <= misalign_d;
      end
   end

   // Buffer storage needs no reset; validity is tracked by count_q
   always_ff @(posedge clk) begin
      if (!reset && push) begin
         buf_data_q[tail_q] <= bus.imem_rdata;
         buf_pc_q[tail_q]   <= req_pc_q;
      end
   end

   assign misalign_err = misalign_q;
   assign fetch_count  = fetch_count_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Self-checking bench for imem_fetch_ctrl: queue-based reference model
// compared every cycle, plus directed literal checks per scenario.
module tb_imem_fetch_ctrl;

   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        halt;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        misalign_err;
   logic [31:0] fetch_count;

   always #5 clk = ~clk;

   imem_fetch_ctrl_if bus ();

   imem_fetch_ctrl #(
      .DEPTH   (DEPTH),
      .RESET_PC(32'h0)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .bus          (bus),
      .halt         (halt),
      .branch_taken (branch_taken),
      .branch_target(branch_target),
      .misalign_err (misalign_err),
      .fetch_count  (fetch_count)
   );

   // IMEM contents: word[i] = i
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a >> 2;
   endfunction

   always @(posedge clk) begin
      if (bus.imem_rd_en)
         bus.imem_rdata <= mem_word(bus.imem_addr);
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t",
                  name, act, exp, $time);
      end
   endtask

   // Reference model: queue of buffered PCs, one optional outstanding read
   logic [31:0] m_q[$];
   logic [31:0] m_pc  = 32'h0;
   logic [31:0] m_req = 32'h0;
   logic [31:0] m_fc  = 32'h0;
   bit          m_infl = 1'b0;
   bit          m_mis  = 1'b0;
   bit          model_on = 1'b0;

   initial begin : model_p
      bit e_valid;
      bit e_pop;
      bit e_issue;
      int occ;
      forever begin
         @(negedge clk);
         e_valid = !reset && (m_q.size() != 0);
         e_pop   = e_valid && bus.instr_ready && !branch_taken;
         occ     = m_q.size() + int'(m_infl) - int'(e_pop);
         e_issue = !reset && !halt && !branch_taken && (occ < DEPTH);
         if (model_on) begin
            check("m_rd_en", 32'(bus.imem_rd_en), 32'(e_issue));
            check("m_addr", bus.imem_addr, m_pc);
            check("m_valid", 32'(bus.instr_valid), 32'(e_valid));
            if (e_valid) begin
               check("m_instr_pc", bus.instr_pc, m_q[0]);
               check("m_instr", bus.instr, mem_word(m_q[0]));
            end
            check("m_misalign", 32'(misalign_err), 32'(m_mis));
            check("m_fetch_count", fetch_count, m_fc);
         end
         @(posedge clk);
         if (reset) begin
            m_q.delete();
            m_pc   = 32'h0;
            m_infl = 1'b0;
            m_fc   = 32'h0;
            m_mis  = 1'b0;
         end else begin
            if (e_pop) begin
               void'(m_q.pop_front());
               m_fc = m_fc + 1;
            end
            if (branch_taken)
               m_q.delete();
            else if (m_infl)
               m_q.push_back(m_req);
            m_mis  = branch_taken && (branch_target[1:0] != 2'b00);
            m_infl = e_issue;
            if (e_issue)
               m_req = m_pc;
            if (branch_taken)
               m_pc = {branch_target[31:2], 2'b00};
            else if (e_issue)
               m_pc = m_pc + 32'd4;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      reset           = 1'b1;
      halt            = 1'b0;
      branch_taken    = 1'b0;
      branch_target   = 32'h0;
      bus.instr_ready = 1'b1;
      tick();
      model_on = 1'b1;
      tick();

      // 1: streaming from reset, ready=1
      reset = 1'b0;
      settle();
      check("t1_rd_en_c0", 32'(bus.imem_rd_en), 32'd1);
      check("t1_addr_c0", bus.imem_addr, 32'h0);
      tick(); settle();
      check("t1_addr_c1", bus.imem_addr, 32'h4);
      check("t1_valid_c1", 32'(bus.instr_valid), 32'd0);
      tick(); settle();
      check("t1_valid_c2", 32'(bus.instr_valid), 32'd1);
      check("t1_pc_c2", bus.instr_pc, 32'h0);
      check("t1_instr_c2", bus.instr, 32'h0);
      tick(); settle();
      check("t1_pc_c3", bus.instr_pc, 32'h4);
      check("t1_instr_c3", bus.instr, 32'h1);
      repeat (6) tick();

      // 2: ready=0 from reset fills the buffer then stalls
      reset = 1'b1;
      bus.instr_ready = 1'b0;
      tick();
      reset = 1'b0;
      settle();
      check("t2_addr_c0", bus.imem_addr, 32'h0);
      tick(); settle();
      check("t2_addr_c1", bus.imem_addr, 32'h4);
      tick(); settle();
      check("t2_rd_en_c2", 32'(bus.imem_rd_en), 32'd0);
      check("t2_pc_c2", bus.instr_pc, 32'h0);
      tick(); tick(); settle();
      check("t2_rd_en_c4", 32'(bus.imem_rd_en), 32'd0);
      check("t2_fc_c4", fetch_count, 32'd0);
      bus.instr_ready = 1'b1;
      settle();
      check("t2_resume_rd_en", 32'(bus.imem_rd_en), 32'd1);
      check("t2_resume_addr", bus.imem_addr, 32'h8);
      tick(); settle();
      check("t2_pc_c5", bus.instr_pc, 32'h4);
      tick(); settle();
      check("t2_pc_c6", bus.instr_pc, 32'h8);
      check("t2_fc_c6", fetch_count, 32'd2);
      repeat (4) tick();

      // 3: redirect to 0x100 in steady state
      branch_taken  = 1'b1;
      branch_target = 32'h100;
      settle();
      check("t3_no_issue", 32'(bus.imem_rd_en), 32'd0);
      tick();
      branch_taken = 1'b0;
      settle();
      check("t3_flushed", 32'(bus.instr_valid), 32'd0);
      check("t3_addr", bus.imem_addr, 32'h100);
      tick(); settle();
      check("t3_still_empty", 32'(bus.instr_valid), 32'd0);
      tick(); settle();
      check("t3_first_valid", 32'(bus.instr_valid), 32'd1);
      check("t3_first_pc", bus.instr_pc, 32'h100);
      check("t3_first_instr", bus.instr, 32'h40);
      repeat (3) tick();

      // 4: misaligned target
      branch_taken  = 1'b1;
      branch_target = 32'h103;
      tick();
      branch_taken = 1'b0;
      settle();
      check("t4_misalign", 32'(misalign_err), 32'd1);
      check("t4_addr", bus.imem_addr, 32'h100);
      tick(); settle();
      check("t4_misalign_clr", 32'(misalign_err), 32'd0);
      repeat (3) tick();

      // 5: halt for 5 cycles with one read in flight
      branch_taken  = 1'b1;
      branch_target = 32'h200;
      tick();
      branch_taken = 1'b0;
      tick();
      halt = 1'b1;
      settle();
      check("t5_halt_rd_en", 32'(bus.imem_rd_en), 32'd0);
      tick(); settle();
      check("t5_drain_valid", 32'(bus.instr_valid), 32'd1);
      check("t5_drain_pc", bus.instr_pc, 32'h200);
      tick(); settle();
      check("t5_empty", 32'(bus.instr_valid), 32'd0);
      tick(); tick(); tick();
      halt = 1'b0;
      settle();
      check("t5_resume_rd_en", 32'(bus.imem_rd_en), 32'd1);
      check("t5_resume_addr", bus.imem_addr, 32'h204);
      repeat (4) tick();

      // 6: PC wrap and mid-stream reset
      branch_taken  = 1'b1;
      branch_target = 32'hFFFF_FFFC;
      tick();
      branch_taken = 1'b0;
      settle();
      check("t6_addr_top", bus.imem_addr, 32'hFFFF_FFFC);
      tick(); settle();
      check("t6_addr_wrap", bus.imem_addr, 32'h0);
      tick(); tick();
      reset = 1'b1;
      settle();
      check("t6_rst_rd_en", 32'(bus.imem_rd_en), 32'd0);
      check("t6_rst_valid", 32'(bus.instr_valid), 32'd0);
      tick();
      reset = 1'b0;
      settle();
      check("t6_addr_after_rst", bus.imem_addr, 32'h0);
      check("t6_fc_after_rst", fetch_count, 32'd0);
      check("t6_valid_after_rst", 32'(bus.instr_valid), 32'd0);
      repeat (5) tick();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
